cdpga_out_seq: RTL



---
 rtl/cdpga_out_seq_if.sv | 26 ++
 rtl/cdpga_out_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cdpga_out_seq_if.sv
// -----------------------------------------------------------------------------
// cdpga_out_seq_if
// Hold handshake between a host/debug requester and the CDPGA-H output
// pattern sequencer. The requester raises hold_req with the value it wants
// on the pins; the sequencer answers with hold_ack once it has given up the
// bus, and keeps driving hold_val until hold_req drops.
//
// Signals:
//   hold_req  requester asks to own the pin bus
//   hold_val  WIDTH-bit value driven on the pins while held
//   hold_ack  sequencer has handed the bus to the requester
//
// Modports:
//   master  requester side (drives hold_req/hold_val, reads hold_ack)
//   slave   sequencer side (reads hold_req/hold_val, drives hold_ack)
// -----------------------------------------------------------------------------
interface cdpga_out_seq_if #(
    parameter int WIDTH = 20
);
    logic             hold_req;
    logic [WIDTH-1:0] hold_val;
    logic             hold_ack;

    modport master (output hold_req, output hold_val, input  hold_ack);
    modport slave  (input  hold_req, input  hold_val, output hold_ack);
endinterface

// File: rtl/cdpga_out_seq.sv
// -----------------------------------------------------------------------------
// cdpga_out_seq
// Output-pattern scheduler for the 20-pin CDPGA-H test output bank. Steps the
// pin bus through walking-one, walking-zero, binary count and all-pin toggle,
// then repeats. A requester on the hold interface can pre-empt the sequence
// and drive a static value; the sequence resumes at the exact step and
// prescaler phase it was interrupted at. All outputs are registered.
//
// Ports:
//   clk        system clock (board domain, 25 MHz)
//   rst_n      synchronous reset, active low
//   en         sequencer enable, level sensitive, highest priority
//   hold_bus   hold handshake (slave side): hold_req, hold_val, hold_ack
//   out        WIDTH-bit pin bus
//   mode       current state: IDLE=0 WALK1=1 WALK0=2 COUNT=3 TOGGLE=4 HOLD=5
//   tick       one-cycle strobe on every pattern step
//   pass_done  one-cycle pulse when a full pass wraps back to WALK1
// -----------------------------------------------------------------------------
module cdpga_out_seq #(
    parameter int WIDTH        = 20,
    parameter int DIV          = 25000,
    parameter int COUNT_STEPS  = 256,
    parameter int TOGGLE_STEPS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    cdpga_out_seq_if.slave     hold_bus,
    output logic [WIDTH-1:0]   out,
    output logic [2:0]         mode,
    output logic               tick,
    output logic               pass_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WALK1  = 3'd1,
        WALK0  = 3'd2,
        COUNT  = 3'd3,
        TOGGLE = 3'd4,
        HOLD   = 3'd5
    } state_e;

    // The step counter must hold the largest per-state step index.
    localparam int STEP_MAX_A = (WIDTH > COUNT_STEPS) ? WIDTH : COUNT_STEPS;
    localparam int STEP_MAX   = (STEP_MAX_A > TOGGLE_STEPS) ? STEP_MAX_A : TOGGLE_STEPS;
    localparam int STEP_W     = (STEP_MAX > 2) ? $clog2(STEP_MAX) : 1;
    localparam int PRESC_W    = 24;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

    state_e              state_q, state_d;
    state_e              saved_state_q, saved_state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic                tick_q, tick_d;
    logic                pass_done_q, pass_done_d;
    logic                hold_ack_q, hold_ack_d;

    // Final step index of each pattern state.
    function automatic logic [STEP_W-1:0] last_step(input state_e s);
        case (s)
            WALK1, WALK0: last_step = STEP_W'(WIDTH - 1);
            COUNT:        last_step = STEP_W'(COUNT_STEPS - 1);
            default:      last_step = STEP_W'(TOGGLE_STEPS - 1);
        endcase
    endfunction

    // Pattern order within one pass; TOGGLE wraps back to WALK1.
    function automatic state_e next_pattern(input state_e s);
        case (s)
            WALK1:   next_pattern = WALK0;
            WALK0:   next_pattern = COUNT;
            COUNT:   next_pattern = TOGGLE;
            default: next_pattern = WALK1;
        endcase
    endfunction

    // Pin value for a pattern state at a given step.
    function automatic logic [WIDTH-1:0] pattern(input state_e s, input logic [STEP_W-1:0] st);
        case (s)
            WALK1:   pattern = WIDTH'(1) << st;
            WALK0:   pattern = ~(WIDTH'(1) << st);
            COUNT:   pattern = WIDTH'(st);
            TOGGLE:  pattern = {WIDTH{st[0]}};
            default: pattern = '0;
        endcase
    endfunction

    // NOTE: every always_comb output is given a default first so that no
    // path leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d       = state_q;
        saved_state_d = saved_state_q;
        step_d        = step_q;
        presc_d       = presc_q;
        tick_d        = 1'b0;
        pass_done_d   = 1'b0;
        hold_ack_d    = 1'b0;

        if (state_q == IDLE) begin
            // Prescaler and step sit at zero so enabling always starts a fresh pass.
            step_d  = '0;
            presc_d = '0;
            if (en) begin
                state_d = WALK1;
            end
        end else if (!en) begin
            state_d = IDLE;
            step_d  = '0;
            presc_d = '0;
        end else if (state_q == HOLD) begin
            // step_q and presc_q stay frozen; they are the saved context.
            if (hold_bus.hold_req) begin
                hold_ack_d = 1'b1;
            end else begin
                state_d = saved_state_q;
            end
        end else if (hold_bus.hold_req) begin
            // Hold beats a coinciding tick: no step advance, no strobe.
            saved_state_d = state_q;
            state_d       = HOLD;
            hold_ack_d    = 1'b1;
        end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (step_q == last_step(state_q)) begin
                step_d      = '0;
                state_d     = next_pattern(state_q);
                pass_done_d = (state_q == TOGGLE);
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end

        // The pin value follows the next state directly, so it changes on the
        // same edge as the transition.
        case (state_d)
            IDLE:    out_d = '0;
            HOLD:    out_d = hold_bus.hold_val;
            default: out_d = pattern(state_d, step_d);
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            saved_state_q <= IDLE;
            step_q        <= '0;
            presc_q       <= '0;
            out_q         <= '0;
            tick_q        <= 1'b0;
            pass_done_q   <= 1'b0;
            hold_ack_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            saved_state_q <= saved_state_d;
            step_q        <= step_d;
            presc_q       <= presc_d;
            out_q         <= out_d;
            tick_q        <= tick_d;
            pass_done_q   <= pass_done_d;
            hold_ack_q    <= hold_ack_d;
        end
    end

    assign out               = out_q;
    assign mode              = 3'(state_q);
    assign tick              = tick_q;
    assign pass_done         = pass_done_q;
    assign hold_bus.hold_ack = hold_ack_q;

endmodule
